// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producers and one consumer around rr_arb_mux.
// master = producer/consumer side (the environment), slave = the arbiter.
interface rr_arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    parameter int SELW  = 2
);
    logic [CH-1:0]       in_valid;
    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_ready;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic [SELW-1:0]     out_sel;
    logic                out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with a single registered output stage.
// Round-robin (MODE=0) or fixed lowest-index priority (MODE=1).
// The grant is recomputed every cycle from in_valid; nothing is latched
// except the output word and the round-robin pointer.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic         clk,
    input  logic         reset,
    rr_arb_mux_if.slave  bus
);
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_eff;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_found;
    logic             accept;
    logic             xfer;
    logic [CH-1:0]    ready_vec;
    logic [WIDTH-1:0] gnt_data;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_sel_q;

    // Output register can take a new word when empty or being drained.
    assign accept  = ~out_valid_q | bus.out_ready;
    // Fixed priority always searches from channel 0.
    assign ptr_eff = (MODE == 1) ? '0 : ptr;

    // Grant search: first pass covers ptr..CH-1, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < CH; i++) begin
            if (!gnt_found && bus.in_valid[i] && (i >= int'(ptr_eff))) begin
                gnt_found = 1'b1;
                gnt_idx   = SELW'(i);
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (!gnt_found && bus.in_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = SELW'(i);
            end
        end
    end

    // One-hot accept to the granted producer; held low during reset.
    always_comb begin
        ready_vec = '0;
        if (gnt_found && accept && !reset) begin
            for (int i = 0; i < CH; i++) begin
                if (gnt_idx == SELW'(i)) ready_vec[i] = 1'b1;
            end
        end
    end

    assign xfer = |ready_vec;

    // Data mux driven only by the granted channel.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (gnt_idx == SELW'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output stage: load on transfer, clear valid on drain, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_data;
            out_sel_q   <= gnt_idx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Round-robin pointer moves past the last winner with an explicit wrap
    // so non-power-of-two channel counts never point at a missing channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (MODE == 0 && xfer) begin
            if (gnt_idx == SELW'(CH - 1)) ptr <= '0;
            else                          ptr <= gnt_idx + SELW'(1);
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin CH=4 table, fixed-priority
// CH=4 sequence, CH=3 wrap sequence, and reset behaviour.
module tb_rr_arb_mux;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    rr_arb_mux_if #(.WIDTH(32), .CH(4), .SELW(2)) bus0 ();
    rr_arb_mux_if #(.WIDTH(32), .CH(4), .SELW(2)) bus1 ();
    rr_arb_mux_if #(.WIDTH(32), .CH(3), .SELW(2)) bus2 ();

    rr_arb_mux #(.WIDTH(32), .CH(4), .SELW(2), .MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    rr_arb_mux #(.WIDTH(32), .CH(4), .SELW(2), .MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    rr_arb_mux #(.WIDTH(32), .CH(3), .SELW(2), .MODE(0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   v;
        logic [127:0] d;
        logic         ordy;
        logic [3:0]   rdy;
        logic         ov;
        logic [31:0]  od;
        logic [1:0]   os;
        logic [1:0]   ptr;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] DFLT = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] DBEF = {32'd4, 32'hDEADBEEF, 32'd2, 32'd1};

    initial begin
        total = 0;
        bad   = 0;

        vt[0]  = '{4'b0000, DFLT, 1'b1, 4'b0000, 1'b0, 32'd0,         2'd0, 2'd0};
        vt[1]  = '{4'b0100, DBEF, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF,  2'd2, 2'd3};
        vt[2]  = '{4'b1111, DFLT, 1'b1, 4'b1000, 1'b1, 32'd4,         2'd3, 2'd0};
        vt[3]  = '{4'b1111, DFLT, 1'b1, 4'b0001, 1'b1, 32'd1,         2'd0, 2'd1};
        vt[4]  = '{4'b1111, DFLT, 1'b1, 4'b0010, 1'b1, 32'd2,         2'd1, 2'd2};
        vt[5]  = '{4'b1111, DFLT, 1'b1, 4'b0100, 1'b1, 32'd3,         2'd2, 2'd3};
        vt[6]  = '{4'b1111, DFLT, 1'b1, 4'b1000, 1'b1, 32'd4,         2'd3, 2'd0};
        vt[7]  = '{4'b1111, DFLT, 1'b1, 4'b0001, 1'b1, 32'd1,         2'd0, 2'd1};
        vt[8]  = '{4'b1111, DFLT, 1'b1, 4'b0010, 1'b1, 32'd2,         2'd1, 2'd2};
        vt[9]  = '{4'b0001, DFLT, 1'b1, 4'b0001, 1'b1, 32'd1,         2'd0, 2'd1};
        vt[10] = '{4'b0110, DFLT, 1'b0, 4'b0000, 1'b1, 32'd1,         2'd0, 2'd1};
        vt[11] = '{4'b0110, DFLT, 1'b0, 4'b0000, 1'b1, 32'd1,         2'd0, 2'd1};
        vt[12] = '{4'b0110, DFLT, 1'b0, 4'b0000, 1'b1, 32'd1,         2'd0, 2'd1};
        vt[13] = '{4'b0110, DFLT, 1'b1, 4'b0010, 1'b1, 32'd2,         2'd1, 2'd2};
        vt[14] = '{4'b0000, DFLT, 1'b1, 4'b0000, 1'b0, 32'd2,         2'd1, 2'd2};
        vt[15] = '{4'b0000, DFLT, 1'b0, 4'b0000, 1'b0, 32'd2,         2'd1, 2'd2};
        vt[16] = '{4'b1000, DFLT, 1'b0, 4'b1000, 1'b1, 32'd4,         2'd3, 2'd0};
        vt[17] = '{4'b0001, DFLT, 1'b0, 4'b0000, 1'b1, 32'd4,         2'd3, 2'd0};
        vt[18] = '{4'b0000, DFLT, 1'b0, 4'b0000, 1'b1, 32'd4,         2'd3, 2'd0};
        vt[19] = '{4'b0000, DFLT, 1'b1, 4'b0000, 1'b0, 32'd4,         2'd3, 2'd0};

        // Reset with requests pending: no accepts, outputs cleared.
        reset = 1'b1;
        bus0.in_valid = 4'b1111; bus0.in_data = DFLT; bus0.out_ready = 1'b1;
        bus1.in_valid = 4'b0000; bus1.in_data = DFLT; bus1.out_ready = 1'b1;
        bus2.in_valid = 3'b000;
        bus2.in_data  = {32'hA2, 32'hA1, 32'hA0};
        bus2.out_ready = 1'b1;
        #2;
        chk("rst_in_ready", 64'(bus0.in_ready), 64'h0);
        chk("rst_out_valid", 64'(bus0.out_valid), 64'h0);
        chk("rst_out_data", 64'(bus0.out_data), 64'h0);
        chk("rst_out_sel", 64'(bus0.out_sel), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        bus0.in_valid = 4'b0000;

        // Round-robin table on dut0.
        for (int k = 0; k < 20; k++) begin
            bus0.in_valid  = vt[k].v;
            bus0.in_data   = vt[k].d;
            bus0.out_ready = vt[k].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", k), 64'(bus0.in_ready), 64'(vt[k].rdy));
            tick();
            chk($sformatf("v%0d_out_valid", k), 64'(bus0.out_valid), 64'(vt[k].ov));
            chk($sformatf("v%0d_out_data", k), 64'(bus0.out_data), 64'(vt[k].od));
            chk($sformatf("v%0d_out_sel", k), 64'(bus0.out_sel), 64'(vt[k].os));
            chk($sformatf("v%0d_ptr", k), 64'(dut0.ptr), 64'(vt[k].ptr));
        end

        // Fixed priority: channel 1 wins repeatedly over channel 3.
        bus1.in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("fp%0d_in_ready", k), 64'(bus1.in_ready), 64'b0010);
            tick();
            chk($sformatf("fp%0d_out_valid", k), 64'(bus1.out_valid), 64'h1);
            chk($sformatf("fp%0d_out_sel", k), 64'(bus1.out_sel), 64'h1);
            chk($sformatf("fp%0d_out_data", k), 64'(bus1.out_data), 64'h2);
        end
        bus1.in_valid = 4'b1000;
        #1;
        chk("fp_ch3_in_ready", 64'(bus1.in_ready), 64'b1000);
        tick();
        chk("fp_ch3_out_sel", 64'(bus1.out_sel), 64'h3);
        chk("fp_ch3_out_data", 64'(bus1.out_data), 64'h4);
        chk("fp_ptr", 64'(dut1.ptr), 64'h0);
        bus1.in_valid = 4'b0000;

        // Three channels: pointer wraps from the last channel to 0.
        bus2.in_valid = 3'b100;
        #1;
        chk("w3_a_in_ready", 64'(bus2.in_ready), 64'b100);
        tick();
        chk("w3_a_out_sel", 64'(bus2.out_sel), 64'h2);
        chk("w3_a_out_data", 64'(bus2.out_data), 64'hA2);
        chk("w3_a_ptr", 64'(dut2.ptr), 64'h0);
        bus2.in_valid = 3'b011;
        #1;
        chk("w3_b_in_ready", 64'(bus2.in_ready), 64'b001);
        tick();
        chk("w3_b_out_sel", 64'(bus2.out_sel), 64'h0);
        chk("w3_b_out_data", 64'(bus2.out_data), 64'hA0);
        #1;
        chk("w3_c_in_ready", 64'(bus2.in_ready), 64'b010);
        tick();
        chk("w3_c_out_sel", 64'(bus2.out_sel), 64'h1);
        chk("w3_c_out_data", 64'(bus2.out_data), 64'hA1);
        chk("w3_c_ptr", 64'(dut2.ptr), 64'h2);
        bus2.in_valid = 3'b000;

        // Reset in the middle of a held word clears it without a clock edge.
        bus0.in_valid  = 4'b0010;
        bus0.out_ready = 1'b0;
        tick();
        chk("mr_pre_out_valid", 64'(bus0.out_valid), 64'h1);
        chk("mr_pre_out_sel", 64'(bus0.out_sel), 64'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("mr_out_valid", 64'(bus0.out_valid), 64'h0);
        chk("mr_out_data", 64'(bus0.out_data), 64'h0);
        chk("mr_out_sel", 64'(bus0.out_sel), 64'h0);
        chk("mr_in_ready", 64'(bus0.in_ready), 64'h0);
        chk("mr_ptr", 64'(dut0.ptr), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        bus0.in_valid = 4'b0000;
        tick();
        chk("idle_out_valid", 64'(bus0.out_valid), 64'h0);
        chk("idle_out_data", 64'(bus0.out_data), 64'h0);
        chk("idle_out_sel", 64'(bus0.out_sel), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
